// File: rtl/down_counter_ctrl.sv
// down_counter_ctrl
// Sequencer that owns a synchronous down counter. A load value and a
// reload mode arrive over a valid/ready config port. The count then runs
// under start/stop/abort control. It can pause and resume, runs one-shot
// or auto-reload, and flags the terminal count.
//
// Parameters
//   W         counter width (q, qb, cfg_value)
//   PRESCALE  count-enable divide ratio (>=1). Used only when the
//             DCC_PRESCALE_EN macro is defined. Otherwise the count
//             advances on every RUN clock.
//
// Ports
//   clk, rst     clock; synchronous active-high reset
//   cfg_valid    config offered
//   cfg_ready    config accepted on cfg_valid && cfg_ready (IDLE/DONE only)
//   cfg_value    load value N
//   cfg_reload   1 = auto-reload, 0 = one-shot
//   start        start from IDLE/DONE, resume from PAUSE
//   stop         pause while in RUN
//   abort        return to IDLE from any state (highest priority)
//   q, qb        registered count and its complement
//   tc           terminal count, high exactly while q == 0 in RUN
//   busy         state is LOAD, RUN or PAUSE
//   done         one-shot count complete (held in DONE)
//   state        IDLE=0, LOAD=1, RUN=2, PAUSE=3, DONE=4
//
// Optional feature macro: DCC_PRESCALE_EN
module down_counter_ctrl #(
  parameter int W        = 4,
  parameter int PRESCALE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [W-1:0] cfg_value,
  input  logic         cfg_reload,
  input  logic         start,
  input  logic         stop,
  input  logic         abort,
  output logic [W-1:0] q,
  output logic [W-1:0] qb,
  output logic         tc,
  output logic         busy,
  output logic         done,
  output logic [2:0]   state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Reject a meaningless divide ratio at elaboration time
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("down_counter_ctrl: PRESCALE must be >= 1");
  end

  state_t         state_r, state_s;
  logic [W-1:0]   q_r, q_s;
  logic [W-1:0]   qb_r;
  logic           tc_r, tc_s;
  logic           done_r, done_s;
  logic           busy_r;
  logic           cfg_ready_r;
  logic [W-1:0]   cfg_n_r;
  logic           cfg_reload_r;
  logic           cfg_loaded_r;
  logic           hs_s;
  logic           loaded_s;
  logic           run_s;      // clock in which the counter may advance
  logic           pre_hit_s;  // prescaler allows a count this clock

  assign hs_s     = cfg_valid && cfg_ready_r;
  // A config accepted in the same clock as start counts as loaded
  assign loaded_s = cfg_loaded_r || hs_s;

`ifdef DCC_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] pre_r;

  assign pre_hit_s = (pre_r == PW'(PRESCALE - 1));

  // Prescaler: cleared on LOAD and in IDLE, frozen outside active counting
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_r <= {PW{1'b0}};
    end else if ((state_r == S_LOAD) || (state_s == S_IDLE)) begin
      pre_r <= {PW{1'b0}};
    end else if (run_s) begin
      pre_r <= pre_hit_s ? {PW{1'b0}} : pre_r + PW'(1);
    end else begin
      pre_r <= pre_r;
    end
  end
`else
  assign pre_hit_s = 1'b1;
`endif

  // Next-state and next-output decode; abort > stop > start
  always_comb begin
    state_s = state_r;
    q_s     = q_r;
    tc_s    = tc_r;
    done_s  = done_r;
    run_s   = 1'b0;

    case (state_r)
      S_IDLE, S_DONE: begin
        if (abort) begin
          state_s = S_IDLE;
          q_s     = {W{1'b0}};
          tc_s    = 1'b0;
          done_s  = 1'b0;
        end else if (start && loaded_s) begin
          state_s = S_LOAD;
          done_s  = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_s = S_IDLE;
          q_s     = {W{1'b0}};
          tc_s    = 1'b0;
          done_s  = 1'b0;
        end else begin
          state_s = S_RUN;
          q_s     = cfg_n_r;
          tc_s    = (cfg_n_r == {W{1'b0}});
        end
      end
      S_RUN: begin
        if (abort) begin
          state_s = S_IDLE;
          q_s     = {W{1'b0}};
          tc_s    = 1'b0;
          done_s  = 1'b0;
        end else if (stop) begin
          state_s = S_PAUSE;
        end else begin
          run_s = 1'b1;
        end
      end
      S_PAUSE: begin
        if (abort) begin
          state_s = S_IDLE;
          q_s     = {W{1'b0}};
          tc_s    = 1'b0;
          done_s  = 1'b0;
        end else if (start) begin
          // The resume clock is itself a counting clock
          state_s = S_RUN;
          run_s   = 1'b1;
        end else begin
          state_s = S_PAUSE;
        end
      end
      default: begin
        state_s = S_IDLE;
        q_s     = {W{1'b0}};
        tc_s    = 1'b0;
        done_s  = 1'b0;
      end
    endcase

    // One count step. q never wraps: at zero it reloads or finishes.
    if (run_s && pre_hit_s) begin
      if (q_r != {W{1'b0}}) begin
        q_s  = q_r - W'(1);
        tc_s = (q_r == W'(1));
      end else if (cfg_reload_r) begin
        q_s  = cfg_n_r;
        tc_s = (cfg_n_r == {W{1'b0}});
      end else begin
        state_s = S_DONE;
        q_s     = {W{1'b0}};
        tc_s    = 1'b0;
        done_s  = 1'b1;
      end
    end else begin
      q_s = q_s;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      q_r         <= {W{1'b0}};
      qb_r        <= {W{1'b1}};
      tc_r        <= 1'b0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
      cfg_ready_r <= 1'b1;
    end else begin
      state_r     <= state_s;
      q_r         <= q_s;
      qb_r        <= ~q_s;
      tc_r        <= tc_s;
      done_r      <= done_s;
      busy_r      <= (state_s == S_LOAD) || (state_s == S_RUN) || (state_s == S_PAUSE);
      cfg_ready_r <= (state_s == S_IDLE) || (state_s == S_DONE);
    end
  end

  // Config storage; survives abort, lost on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_n_r      <= {W{1'b0}};
      cfg_reload_r <= 1'b0;
      cfg_loaded_r <= 1'b0;
    end else if (hs_s) begin
      cfg_n_r      <= cfg_value;
      cfg_reload_r <= cfg_reload;
      cfg_loaded_r <= 1'b1;
    end else begin
      cfg_n_r      <= cfg_n_r;
      cfg_reload_r <= cfg_reload_r;
      cfg_loaded_r <= cfg_loaded_r;
    end
  end

  assign q         = q_r;
  assign qb        = qb_r;
  assign tc        = tc_r;
  assign done      = done_r;
  assign busy      = busy_r;
  assign cfg_ready = cfg_ready_r;
  assign state     = state_r;

endmodule

// File: tb/tb_down_counter_ctrl.sv
// Directed self-checking bench for down_counter_ctrl (W=4, PRESCALE=4).
module tb_down_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst, cfg_valid, cfg_reload, start, stop, abort;
  logic [3:0] cfg_value;
  logic       cfg_ready, tc, busy, done;
  logic [3:0] q, qb;
  logic [2:0] state;
  int         total = 0;
  int         bad = 0;

  down_counter_ctrl dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_value(cfg_value), .cfg_reload(cfg_reload), .start(start),
    .stop(stop), .abort(abort), .q(q), .qb(qb), .tc(tc), .busy(busy),
    .done(done), .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cfg_valid = 1'b0; cfg_reload = 1'b0; cfg_value = 4'd0;
    start = 1'b0; stop = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs();
    repeat (5) tick();
    rst = 1'b0;
    total++; if (q !== 4'd0) begin bad++; $display("FAIL reset_q got=%0h exp=0", q); end
    total++; if (qb !== 4'hF) begin bad++; $display("FAIL reset_qb got=%0h exp=f", qb); end
    total++; if (tc !== 1'b0) begin bad++; $display("FAIL reset_tc got=%b exp=0", tc); end
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_cfg_ready got=%b exp=1", cfg_ready); end
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL reset_busy_done got=%b exp=00", {busy, done}); end
    total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
    start = 1'b1; tick(); start = 1'b0;
    total++; if (state !== 3'd0) begin bad++; $display("FAIL start_no_cfg got=%0d exp=0", state); end
    tick();
    total++; if (state !== 3'd0) begin bad++; $display("FAIL start_no_cfg2 got=%0d exp=0", state); end
  endtask

  task automatic test_oneshot();
    cfg_valid = 1'b1; cfg_value = 4'd5; cfg_reload = 1'b0; tick(); cfg_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    total++; if (state !== 3'd1 || busy !== 1'b1 || cfg_ready !== 1'b0) begin
      bad++; $display("FAIL oneshot_load state=%0d busy=%b rdy=%b exp=1/1/0", state, busy, cfg_ready); end
    for (int i = 5; i >= 0; i--) begin
      tick();
      total++; if (q !== 4'(i) || qb !== ~4'(i) || tc !== (i == 0) || state !== 3'd2) begin
        bad++; $display("FAIL oneshot_count q=%0d qb=%0h tc=%b st=%0d exp_q=%0d", q, qb, tc, state, i); end
    end
    tick();
    total++; if (state !== 3'd4 || done !== 1'b1 || cfg_ready !== 1'b1 || tc !== 1'b0 || q !== 4'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL oneshot_done st=%0d done=%b rdy=%b tc=%b q=%0d busy=%b", state, done, cfg_ready, tc, q, busy); end
    tick();
    total++; if (done !== 1'b1 || state !== 3'd4) begin bad++; $display("FAIL done_hold done=%b st=%0d exp=1/4", done, state); end
  endtask

  task automatic test_reload();
    int e;
    // Config and start together in DONE
    cfg_valid = 1'b1; cfg_value = 4'd3; cfg_reload = 1'b1; start = 1'b1; tick();
    cfg_valid = 1'b0; start = 1'b0;
    total++; if (state !== 3'd1 || done !== 1'b0) begin bad++; $display("FAIL reload_load st=%0d done=%b exp=1/0", state, done); end
    for (int k = 0; k < 12; k++) begin
      tick();
      e = 3 - (k % 4);
      total++; if (q !== 4'(e) || tc !== (e == 0) || state !== 3'd2) begin
        bad++; $display("FAIL reload_seq k=%0d q=%0d tc=%b st=%0d exp_q=%0d", k, q, tc, state, e); end
    end
    abort = 1'b1; tick(); abort = 1'b0;
    total++; if (state !== 3'd0 || q !== 4'd0 || tc !== 1'b0) begin bad++; $display("FAIL reload_abort st=%0d q=%0d tc=%b", state, q, tc); end
    cfg_valid = 1'b1; cfg_value = 4'd0; cfg_reload = 1'b1; tick(); cfg_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      total++; if (q !== 4'd0 || tc !== 1'b1 || state !== 3'd2) begin
        bad++; $display("FAIL reload_zero k=%0d q=%0d tc=%b st=%0d exp=0/1/2", k, q, tc, state); end
    end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_pause();
    cfg_valid = 1'b1; cfg_value = 4'd9; cfg_reload = 1'b0; tick(); cfg_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (6) tick();
    total++; if (q !== 4'd4) begin bad++; $display("FAIL pause_pre q=%0d exp=4", q); end
    // start while running is ignored
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();   // stop still high in PAUSE: ignored
      total++; if (q !== 4'd4 || state !== 3'd3 || tc !== 1'b0 || busy !== 1'b1) begin
        bad++; $display("FAIL pause_hold k=%0d q=%0d st=%0d tc=%b busy=%b", k, q, state, tc, busy); end
    end
    stop = 1'b0; start = 1'b1; tick(); start = 1'b0;
    total++; if (q !== 4'd3 || state !== 3'd2) begin bad++; $display("FAIL resume q=%0d st=%0d exp=3/2", q, state); end
    tick();
    total++; if (q !== 4'd2) begin bad++; $display("FAIL resume_next q=%0d exp=2", q); end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_abort_priority();
    start = 1'b1; tick(); start = 1'b0;  // config 9 one-shot retained
    repeat (4) tick();
    total++; if (q !== 4'd6) begin bad++; $display("FAIL abort_pre q=%0d exp=6", q); end
    abort = 1'b1; stop = 1'b1; start = 1'b1; tick();
    abort = 1'b0; stop = 1'b0; start = 1'b0;
    total++; if (state !== 3'd0 || q !== 4'd0 || tc !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL abort_all st=%0d q=%0d tc=%b busy=%b", state, q, tc, busy); end
    cfg_valid = 1'b1; cfg_value = 4'd2; cfg_reload = 1'b0; start = 1'b1; tick();
    cfg_valid = 1'b0; start = 1'b0;
    total++; if (state !== 3'd1) begin bad++; $display("FAIL cfg_start_load st=%0d exp=1", state); end
    tick();
    total++; if (q !== 4'd2 || state !== 3'd2) begin bad++; $display("FAIL cfg_start_q q=%0d st=%0d exp=2/2", q, state); end
    tick(); tick();
    total++; if (q !== 4'd0 || tc !== 1'b1) begin bad++; $display("FAIL n2_zero q=%0d tc=%b exp=0/1", q, tc); end
    tick();
    total++; if (state !== 3'd4 || q !== 4'd0 || qb !== 4'hF) begin bad++; $display("FAIL n2_done st=%0d q=%0d qb=%0h", state, q, qb); end
    abort = 1'b1; tick(); abort = 1'b0;
    total++; if (done !== 1'b0 || state !== 3'd0) begin bad++; $display("FAIL done_abort done=%b st=%0d exp=0/0", done, state); end
    stop = 1'b1; tick(); stop = 1'b0;
    total++; if (state !== 3'd0) begin bad++; $display("FAIL stop_idle st=%0d exp=0", state); end
    start = 1'b1; tick(); start = 1'b0; tick();
    total++; if (q !== 4'd2 || state !== 3'd2) begin bad++; $display("FAIL cfg_retained q=%0d st=%0d exp=2/2", q, state); end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_rst_mid();
    cfg_valid = 1'b1; cfg_value = 4'd9; cfg_reload = 1'b1; tick(); cfg_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    total++; if (q !== 4'd7) begin bad++; $display("FAIL rst_pre q=%0d exp=7", q); end
    rst = 1'b1; tick(); rst = 1'b0;
    total++; if (q !== 4'd0 || qb !== 4'hF || tc !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || state !== 3'd0 || cfg_ready !== 1'b1) begin
      bad++; $display("FAIL rst_mid q=%0d qb=%0h tc=%b busy=%b done=%b st=%0d rdy=%b", q, qb, tc, busy, done, state, cfg_ready); end
    start = 1'b1; tick(); start = 1'b0; tick();
    total++; if (state !== 3'd0) begin bad++; $display("FAIL rst_cfg_lost st=%0d exp=0", state); end
  endtask

`ifdef DCC_PRESCALE_EN
  task automatic test_prescale();
    int e;
    cfg_valid = 1'b1; cfg_value = 4'd2; cfg_reload = 1'b0; tick(); cfg_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      e = 2 - (k / 4);
      total++; if (q !== 4'(e) || tc !== (e == 0) || state !== 3'd2) begin
        bad++; $display("FAIL prescale k=%0d q=%0d tc=%b st=%0d exp_q=%0d", k, q, tc, state, e); end
    end
    tick();
    total++; if (state !== 3'd4 || done !== 1'b1) begin bad++; $display("FAIL prescale_done st=%0d done=%b", state, done); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef DCC_PRESCALE_EN
    test_prescale();
`else
    test_oneshot();
    test_reload();
    test_pause();
    test_abort_priority();
    test_rst_mid();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
